// File: rtl/encoder16x4_queue.sv
// Queued 16-to-4 event encoder: it captures request events and presents one index at a time over a valid/ready handshake.
// Build option: define ENCODER16X4_ROUND_ROBIN_EN to get round-robin selection (the default is fixed lowest-index priority).
//
// state     | meaning
// S_IDLE    | nothing presented, valid=0
// S_PRESENT | a holds a pending event, valid=1
module encoder16x4_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  input  logic        ready,
  output logic [3:0]  a,
  output logic        valid,
  output logic [15:0] pending
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [15:0] pend_q, pend_d;

  logic        hs;
  logic [15:0] acc_mask;
  logic [15:0] eff;
  logic [3:0]  sel;

  assign hs       = (state_q == S_PRESENT) && ready;
  assign acc_mask = hs ? (16'h0001 << a_q) : 16'h0000;
  assign eff      = (pend_q & ~acc_mask) | (en ? d : 16'h0000);

`ifdef ENCODER16X4_ROUND_ROBIN_EN
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] ptr_eff;

  // A handshake in this cycle moves the search origin at once, so the next pick already skips the index just accepted.
  assign ptr_eff = hs ? a_q : ptr_q;
  assign ptr_d   = ptr_eff;

  function automatic logic [3:0] pick_rr(input logic [15:0] v, input logic [3:0] start);
    logic [3:0] r;
    logic [3:0] idx;
    logic       found;
    r     = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'd1 + 4'(i);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign sel = pick_rr(eff, ptr_eff);

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 4'hF;
    else     ptr_q <= ptr_d;
  end
`else
  function automatic logic [3:0] pick_low(input logic [15:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign sel = pick_low(eff);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    pend_d  = eff;
    case (state_q)
      S_IDLE: begin
        if (eff != 16'h0000) begin
          a_d     = sel;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ready) begin
          if (eff != 16'h0000) a_d = sel;
          else                 state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 4'h0;
      pend_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
    end
  end

  assign a       = a_q;
  assign valid   = (state_q == S_PRESENT);
  assign pending = pend_q;

endmodule
